// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider, one trial subtract
//               (invert-B, carry-in 1) per iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seq_restoring_divider_if.slave bus
);
    localparam int               c_CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    // The partial remainder stays below the divisor, so its top bit is always
    // zero between iterations; only the shifted trial value needs WIDTH+1 bits.
    logic [WIDTH-1:0]   r_r;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [WIDTH:0]     w_shift_r;
    logic [WIDTH:0]     w_trial;
    logic               w_no_borrow;
    logic [WIDTH-1:0]   w_next_r;
    logic [WIDTH-1:0]   w_next_q;

    always_comb begin
        w_shift_r   = {r_r, r_q[WIDTH-1]};
        w_trial     = w_shift_r + ~{1'b0, r_d} + (WIDTH+1)'(1);
        w_no_borrow = ~w_trial[WIDTH];
        w_next_r    = w_no_borrow ? w_trial[WIDTH-1:0] : w_shift_r[WIDTH-1:0];
        w_next_q    = {r_q[WIDTH-2:0], w_no_borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_q   <= bus.dividend;
                        r_d   <= bus.divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_dbz <= 1'b0;
                        if (bus.divisor != '0) begin
                            r_state <= c_ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            // Divide by zero resolves immediately without iterating.
                            r_state     <= c_ST_DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_r   <= w_next_r;
                    r_q   <= w_next_q;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state     <= c_ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_next_q;
                        r_remainder <= w_next_r;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Directed self-checking bench for seq_restoring_divider (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) dif ();

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands during the current cycle; returns sampling cycle 1.
    task automatic do_start(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv);
        dif.start    = 1'b1;
        dif.dividend = dd;
        dif.divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    // Busy for n_busy cycles, then done; ends sampling the done cycle.
    task automatic expect_run(input string tag, input int n_busy);
        for (int c = 1; c <= n_busy + 1; c++) begin
            if (c > 1) @(negedge clk);
            check({tag, "_busy"}, {31'd0, dif.busy}, {31'd0, c <= n_busy});
            check({tag, "_done"}, {31'd0, dif.done}, {31'd0, c == n_busy + 1});
        end
    endtask

    task automatic expect_result(input string tag, input int q, input int r, input logic z);
        check({tag, "_q"},   32'(dif.quotient),    32'(q));
        check({tag, "_r"},   32'(dif.remainder),   32'(r));
        check({tag, "_dbz"}, {31'd0, dif.div_by_zero}, {31'd0, z});
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        expect_result("rst", 0, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 13/3 with full latency profile and hold in IDLE afterwards
        do_start(4'd13, 4'd3);
        expect_run("d13_3", 4);
        expect_result("d13_3", 4, 1, 1'b0);
        @(negedge clk);
        check("d13_3_done_drop", {31'd0, dif.done}, 32'd0);
        check("d13_3_idle_busy", {31'd0, dif.busy}, 32'd0);
        expect_result("d13_3_hold", 4, 1, 1'b0);

        do_start(4'd15, 4'd1);  expect_run("d15_1", 4);   expect_result("d15_1", 15, 0, 1'b0);
        @(negedge clk);
        do_start(4'd5, 4'd7);   expect_run("d5_7", 4);    expect_result("d5_7", 0, 5, 1'b0);
        @(negedge clk);
        do_start(4'd0, 4'd9);   expect_run("d0_9", 4);    expect_result("d0_9", 0, 0, 1'b0);
        @(negedge clk);
        do_start(4'd15, 4'd15); expect_run("d15_15", 4);  expect_result("d15_15", 1, 0, 1'b0);
        @(negedge clk);

        // Divide by zero, then a normal divide clears the flag
        do_start(4'd9, 4'd0);   expect_run("d9_0", 0);    expect_result("d9_0", 15, 9, 1'b1);
        @(negedge clk);
        check("d9_0_done_drop", {31'd0, dif.done}, 32'd0);
        do_start(4'd8, 4'd2);   expect_run("d8_2", 4);    expect_result("d8_2", 4, 0, 1'b0);
        @(negedge clk);

        // Start during RUN is ignored
        do_start(4'd14, 4'd4);
        check("mid_c1_busy", {31'd0, dif.busy}, 32'd1);
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 4'd7; dif.divisor = 4'd2;
        check("mid_c2_busy", {31'd0, dif.busy}, 32'd1);
        @(negedge clk);
        dif.start = 1'b0;
        check("mid_c3_busy", {31'd0, dif.busy}, 32'd1);
        @(negedge clk);
        check("mid_c4_busy", {31'd0, dif.busy}, 32'd1);
        @(negedge clk);
        check("mid_c5_done", {31'd0, dif.done}, 32'd1);
        expect_result("mid", 3, 2, 1'b0);
        @(negedge clk);
        check("mid_after_busy", {31'd0, dif.busy}, 32'd0);
        check("mid_after_done", {31'd0, dif.done}, 32'd0);

        // Back-to-back: new start held during the DONE cycle
        do_start(4'd12, 4'd5);
        expect_run("b2b_a", 4);
        expect_result("b2b_a", 2, 2, 1'b0);
        dif.start = 1'b1; dif.dividend = 4'd11; dif.divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        expect_run("b2b_b", 4);
        expect_result("b2b_b", 3, 2, 1'b0);
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse
        do_start(4'd10, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, dif.busy}, 32'd0);
        check("abort_done", {31'd0, dif.done}, 32'd0);
        expect_result("abort", 0, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, dif.done}, 32'd0);
        end
        do_start(4'd6, 4'd2);   expect_run("d6_2", 4);    expect_result("d6_2", 3, 0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
